// File: rtl/os_generator.sv
// ============================================================================
// os_generator
// ----------------------------------------------------------------------------
// TX counterpart of os_checker in the PCIe LTSSM path. Builds 128-bit TS1/TS2
// ordered sets for the current LTSSM substate and streams them over a
// valid/ready handshake. Also counts the ordered sets accepted since the last
// substate change and flags when the minimum-send count has been reached.
//
// Parameters:
//   DOWNSTREAM    1: propose link number in Config.LinkWidthStart, 0: send PAD
//   MIN_TS_COUNT  accepted-OS count at which min_sent asserts (1..2047)
//   N_FTS         value placed in symbol 2
//
// Ports:
//   clk                     clock
//   reset                   asynchronous reset, active-high
//   substate[3:0]           LTSSM substate (0 detectQuiet .. 9 configurationIdle)
//   tx_enable               permits ordered-set generation
//   linkNumber[7:0]         link number for configuration substates
//   laneNumber[7:0]         lane number for configuration substates
//   rateid[7:0]             data-rate identifier (symbol 3)
//   os_ready                downstream accepts orderedset this cycle
//   upconfigure_capability  (OS_GEN_UPCONFIG_EN only) s4 bit 6 of TS2
//   orderedset[127:0]       ordered set, symbol k at bits [8k+7:8k]
//   os_valid                orderedset is valid
//   tx_count[10:0]          accepted OS in current substate, saturates at 2047
//   min_sent                tx_count >= MIN_TS_COUNT
//
// Build option: define OS_GEN_UPCONFIG_EN to add upconfigure_capability.
// ============================================================================
module os_generator #(
    parameter int          DOWNSTREAM   = 0,
    parameter int          MIN_TS_COUNT = 16,
    parameter logic [7:0]  N_FTS        = 8'd0
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [3:0]     substate,
    input  logic           tx_enable,
    input  logic [7:0]     linkNumber,
    input  logic [7:0]     laneNumber,
    input  logic [7:0]     rateid,
    input  logic           os_ready,
`ifdef OS_GEN_UPCONFIG_EN
    input  logic           upconfigure_capability,
`endif
    output logic [127:0]   orderedset,
    output logic           os_valid,
    output logic [10:0]    tx_count,
    output logic           min_sent
);

    localparam logic [7:0]  PAD     = 8'hF7;
    localparam logic [7:0]  TS1_ID  = 8'h2A;
    localparam logic [7:0]  TS2_ID  = 8'h25;
    localparam logic [10:0] CNT_MAX = 11'd2047;
    localparam logic [10:0] MIN_CNT = 11'(MIN_TS_COUNT);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t         state_q;
    logic [3:0]     substate_q;
    logic [127:0]   os_q;
    logic           valid_q;
    logic [10:0]    count_q;
    logic [10:0]    count_d;
    logic [127:0]   os_load_d;
    logic           tx_sub;
    logic           accept;

    logic [7:0]     link_sym;
    logic [7:0]     lane_sym;
    logic [7:0]     ts_id;
    logic [7:0]     ctrl_sym;

    assign tx_sub = tx_enable && (substate_q >= 4'd2) && (substate_q <= 4'd8);
    assign accept = valid_q && os_ready;

    // Ordered-set content for the registered substate; only loaded when tx_sub.
    always_comb begin
        link_sym = PAD;
        lane_sym = PAD;
        ts_id    = TS1_ID;
        ctrl_sym = '0;
        case (substate_q)
            4'd3: ts_id = TS2_ID;
            4'd4: begin
                if (DOWNSTREAM != 0) link_sym = linkNumber;
            end
            4'd5: link_sym = linkNumber;
            4'd6, 4'd7: begin
                link_sym = linkNumber;
                lane_sym = laneNumber;
            end
            4'd8: begin
                link_sym = linkNumber;
                lane_sym = laneNumber;
                ts_id    = TS2_ID;
            end
            default: ;
        endcase
`ifdef OS_GEN_UPCONFIG_EN
        if (substate_q == 4'd3 || substate_q == 4'd8)
            ctrl_sym[6] = upconfigure_capability;
`endif
        os_load_d = {{11{ts_id}}, ctrl_sym, rateid, N_FTS, lane_sym, link_sym};
    end

    // A substate change wins over a same-cycle accept.
    always_comb begin
        count_d = count_q;
        if (substate != substate_q)
            count_d = '0;
        else if (accept && count_q != CNT_MAX)
            count_d = count_q + 11'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            substate_q <= '0;
            os_q       <= '0;
            valid_q    <= 1'b0;
            count_q    <= '0;
        end else begin
            substate_q <= substate;
            count_q    <= count_d;
            case (state_q)
                IDLE: begin
                    if (tx_sub) begin
                        state_q <= SEND;
                        valid_q <= 1'b1;
                        os_q    <= os_load_d;
                    end
                end
                SEND: begin
                    // Held OS stays on the bus until accepted, whatever
                    // tx_enable or substate do meanwhile.
                    if (os_ready) begin
                        if (tx_sub) begin
                            os_q <= os_load_d;
                        end else begin
                            state_q <= IDLE;
                            valid_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign orderedset = os_q;
    assign os_valid   = valid_q;
    assign tx_count   = count_q;
    assign min_sent   = (count_q >= MIN_CNT);

endmodule

// File: tb/tb_os_generator.sv
module tb_os_generator;

    localparam int         TB_DOWNSTREAM = 0;
    localparam int         TB_MIN        = 16;
    localparam logic [7:0] TB_NFTS       = 8'h00;

    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   substate;
    logic         tx_enable;
    logic [7:0]   linkNumber;
    logic [7:0]   laneNumber;
    logic [7:0]   rateid;
    logic         os_ready;
    logic         upcfg;
    logic [127:0] orderedset;
    logic         os_valid;
    logic [10:0]  tx_count;
    logic         min_sent;

    int checks = 0;
    int errors = 0;

    // Reference state
    logic [127:0] m_os;
    logic         m_valid;
    int           m_cnt;
    int           m_subq;

    os_generator #(
        .DOWNSTREAM   (TB_DOWNSTREAM),
        .MIN_TS_COUNT (TB_MIN),
        .N_FTS        (TB_NFTS)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .substate   (substate),
        .tx_enable  (tx_enable),
        .linkNumber (linkNumber),
        .laneNumber (laneNumber),
        .rateid     (rateid),
        .os_ready   (os_ready),
`ifdef OS_GEN_UPCONFIG_EN
        .upconfigure_capability (upcfg),
`endif
        .orderedset (orderedset),
        .os_valid   (os_valid),
        .tx_count   (tx_count),
        .min_sent   (min_sent)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Ordered set as described by the symbol table.
    function automatic logic [127:0] exp_os(input int s, input logic [7:0] link,
                                            input logic [7:0] lane, input logic [7:0] rate,
                                            input logic up);
        logic [7:0]   sym [16];
        logic [127:0] r;
        bit           ts2;
        ts2 = (s == 3) || (s == 8);
        for (int k = 5; k < 16; k++) sym[k] = ts2 ? 8'h25 : 8'h2A;
        sym[0] = 8'hF7;
        sym[1] = 8'hF7;
        if (s == 4 && TB_DOWNSTREAM != 0) sym[0] = link;
        if (s >= 5 && s <= 8) sym[0] = link;
        if (s >= 6 && s <= 8) sym[1] = lane;
        sym[2] = TB_NFTS;
        sym[3] = rate;
`ifdef OS_GEN_UPCONFIG_EN
        sym[4] = (ts2 && up) ? 8'h40 : 8'h00;
`else
        sym[4] = 8'h00;
        if (up) sym[4] = 8'h00;
`endif
        r = '0;
        for (int k = 0; k < 16; k++) r[8*k +: 8] = sym[k];
        return r;
    endfunction

    task automatic model_reset();
        m_os = '0; m_valid = 1'b0; m_cnt = 0; m_subq = 0;
    endtask

    task automatic compare(input string ph);
        check({ph, "_valid"}, 128'(os_valid), 128'(m_valid));
        check({ph, "_count"}, 128'(tx_count), 128'(m_cnt));
        check({ph, "_min"},   128'(min_sent), 128'(m_cnt >= TB_MIN));
        if (m_valid) check({ph, "_os"}, orderedset, m_os);
        else if (reset) check({ph, "_os_rst"}, orderedset, 128'd0);
    endtask

    // One clock edge: advance the reference from pre-edge inputs, then compare.
    task automatic tick(input string ph);
        bit accept, txsub;
        @(posedge clk);
        if (reset) begin
            model_reset();
        end else begin
            accept = m_valid && os_ready;
            txsub  = tx_enable && m_subq >= 2 && m_subq <= 8;
            if (!m_valid || accept) begin
                if (txsub) begin
                    m_os    = exp_os(m_subq, linkNumber, laneNumber, rateid, upcfg);
                    m_valid = 1'b1;
                end else begin
                    m_valid = 1'b0;
                end
            end
            if (int'(substate) != m_subq) m_cnt = 0;
            else if (accept && m_cnt < 2047) m_cnt++;
            m_subq = int'(substate);
        end
        #1 compare(ph);
    endtask

    initial begin
        reset = 1'b1; substate = 4'd2; tx_enable = 1'b1; os_ready = 1'b1;
        linkNumber = 8'h05; laneNumber = 8'h02; rateid = 8'h11; upcfg = 1'b0;
        model_reset();
        #1 compare("reset");
        tick("reset"); tick("reset");
        reset = 1'b0;

        // Streaming in pollingActive, first valid on 2nd edge after release.
        tick("start");
        check("first_not_yet", 128'(os_valid), 128'd0);
        tick("start");
        check("first_valid", 128'(os_valid), 128'd1);
        check("first_ts1", orderedset, {{11{8'h2A}}, 8'h00, 8'h11, 8'h00, 8'hF7, 8'hF7});
        for (int i = 0; i < 20; i++) begin
            rateid = 8'($urandom);
            tick("poll");
        end

        // Backpressure.
        os_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            rateid = 8'($urandom);
            tick("stall");
        end
        os_ready = 1'b1;
        for (int i = 0; i < 5; i++) tick("resume");

        // Substate change to pollingConfiguration.
        substate = 4'd3;
        for (int i = 0; i < 25; i++) tick("pcfg");
        check("ts2_id", 128'(orderedset[127:120]), 128'h25);

        // Configuration substates with link/lane numbers.
        substate = 4'd6; linkNumber = 8'h05; laneNumber = 8'h02;
        for (int i = 0; i < 5; i++) tick("lnwait");
        check("lnwait_s0", 128'(orderedset[7:0]), 128'h05);
        check("lnwait_s1", 128'(orderedset[15:8]), 128'h02);
        check("lnwait_s5", 128'(orderedset[47:40]), 128'h2A);
        substate = 4'd4;
        for (int i = 0; i < 5; i++) tick("lwstart");
        check("lwstart_s0", 128'(orderedset[7:0]), (TB_DOWNSTREAM != 0) ? 128'h05 : 128'hF7);

        // Randomised traffic.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 19) == 0) substate = 4'($urandom_range(0, 9));
            tx_enable  = ($urandom_range(0, 7) != 0);
            os_ready   = ($urandom_range(0, 3) != 0);
            linkNumber = 8'($urandom);
            laneNumber = 8'($urandom);
            rateid     = 8'($urandom);
            upcfg      = 1'($urandom);
            tick("rand");
        end

        // Saturation.
        substate = 4'd2; tx_enable = 1'b1; os_ready = 1'b1;
        for (int i = 0; i < 2100; i++) tick("sat");
        check("sat_count", 128'(tx_count), 128'd2047);
        check("sat_min", 128'(min_sent), 128'd1);

        // Upconfigure bit in configurationComplete.
        substate = 4'd8; upcfg = 1'b1;
        for (int i = 0; i < 4; i++) tick("cfgcpl");

        // Reset while an OS is held.
        os_ready = 1'b0;
        for (int i = 0; i < 3; i++) tick("hold");
        check("hold_valid", 128'(os_valid), 128'd1);
        #2 reset = 1'b1;
        #1;
        check("rst_async_valid", 128'(os_valid), 128'd0);
        check("rst_async_count", 128'(tx_count), 128'd0);
        check("rst_async_os", orderedset, 128'd0);
        model_reset();
        tick("inreset");
        reset = 1'b0; os_ready = 1'b1;
        for (int i = 0; i < 6; i++) tick("post");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got 1 exp 0");
        $fatal(1, "timeout");
    end

endmodule
